muxn_pipe: RTL and testbench
============================

Name: muxn_pipe

Overview:
- Parametrised N:1 result-select mux for the pipelined datapath; generalises the existing 32-bit 2:1 select.
- Selects one of NUM_IN WIDTH-bit sources and registers the result.
- Input and output use valid/ready handshakes.
- A one-entry skid buffer allows full throughput under back-pressure.
- Placement: writeback / ALU-source select between pipeline stages.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- NUM_IN, 4, number of sources; must be >= 2.
- SEL_W, $clog2(NUM_IN), select width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  upstream has a valid select and data.
- in_ready  output  1  block can accept; a transfer occurs when in_valid and in_ready are both 1.
- sel  input  SEL_W  source index.
- data_in  input  NUM_IN*WIDTH  flattened sources; source k is data_in[k*WIDTH +: WIDTH].
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both 1.
- out_data  output  WIDTH  registered selected value.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at a clk edge) clears state to EMPTY and forces out_valid=0, out_data=0, in_ready=0, skid register=0.
- in_ready goes to 1 on the first edge with rst_n=1.
- A reset mid-operation discards both stored entries. There is no drain.
- Select: sel < NUM_IN picks source sel. Any sel >= NUM_IN produces all-zero data, which can only happen when NUM_IN is not a power of 2.
- Latency: the value accepted at edge t appears on out_data with out_valid=1 after edge t, as seen in cycle t+1.
- There is no combinational path from in_* to out_*.
- in_ready is a register output: 1 exactly when the skid register is empty. There is no combinational path from out_ready to in_ready.
- State machine (main register M, skid register S):
  - EMPTY (out_valid=0, in_ready=1): on accept, load M and go to ONE.
  - ONE (out_valid=1, in_ready=1):
    - accept and output transfer: load M with the new value, stay in ONE.
    - accept, no output transfer: load S with the new value, go to FULL.
    - output transfer only: go to EMPTY.
    - neither: hold.
  - FULL (out_valid=1, in_ready=0):
    - output transfer: M <= S, go to ONE.
    - otherwise hold.
    - Input is never accepted in FULL.
- Ordering: strict FIFO order. No value is dropped or duplicated.
- out_data is stable while out_valid=1 and out_ready=0.
- Inputs sampled while in_valid=0, or while in_ready=0, are ignored.

Optional Feature:
- Macro: MUXN_PIPE_SEL_ERR_EN.
- When defined:
  - Adds output sel_err (1 bit), which travels with the data through M and S.
  - sel_err is 1 for the entry whose accepted sel was >= NUM_IN.
  - It is valid only when out_valid=1 and resets to 0.
- When undefined: the port is absent and out-of-range selects silently yield zero.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=0; in_ready=1 one cycle after rst_n rises.
- Basic select: NUM_IN=4, sources 0x11,0x22,0x33,0x44, out_ready=1, sel=2 then 3 -> out_data 0x33 then 0x44, each one cycle after acceptance.
- Back-pressure: out_ready=0, push 0xA then 0xB -> in_ready=0 after the second push; raise out_ready -> 0xA, then 0xB, then out_valid=0.
- Streaming: in_valid=1 and out_ready=1 for 16 cycles with incrementing sources -> 16 outputs in order, in_ready=1 throughout.
- Out-of-range select: NUM_IN=3, sel=3 -> out_data=0; with MUXN_PIPE_SEL_ERR_EN, sel_err=1 for that entry only.
- Reset in FULL: fill both entries, assert rst_n=0 for one cycle -> out_valid=0, neither stored value ever appears on out_data.

Source files
------------

// File: rtl/muxn_pipe.sv
// -----------------------------------------------------------------------------
// muxn_pipe
//
// Parametrised N:1 result-select mux with a registered output stage and a
// one-entry skid buffer, for source selection between pipeline stages
// (writeback / ALU-source select). Generalises the 32-bit 2:1 select.
//
// Parameters:
//   WIDTH   data width of each source and of the output (default 32)
//   NUM_IN  number of sources, must be >= 2 (default 4)
//   SEL_W   select width, derived as $clog2(NUM_IN)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   upstream offers sel/data_in
//   in_ready   block can accept (registered, 1 when skid register empty)
//   sel        source index; values >= NUM_IN select all-zero data
//   data_in    flattened sources, source k = data_in[k*WIDTH +: WIDTH]
//   out_valid  out_data holds a valid result
//   out_ready  downstream accepts
//   out_data   registered selected value
//   sel_err    (only with MUXN_PIPE_SEL_ERR_EN) entry's sel was >= NUM_IN
//
// Optional feature macro: MUXN_PIPE_SEL_ERR_EN adds the sel_err output,
// which travels with the data through the main and skid registers.
//
// State table:
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_EMPTY | no entry held; out_valid=0
//   ST_ONE   | main register M valid, skid S empty; accepting
//   ST_FULL  | M and S both valid; input stalled until M drains
// -----------------------------------------------------------------------------
module muxn_pipe #(
    parameter int  WIDTH  = 32,
    parameter int  NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data
`ifdef MUXN_PIPE_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   m_data;
    logic [WIDTH-1:0]   s_data;
    logic [WIDTH-1:0]   sel_data;
    logic               accept;
    logic               out_fire;
    logic               load_m_in;
    logic               load_m_s;
    logic               load_s;
`ifdef MUXN_PIPE_SEL_ERR_EN
    logic               sel_oor;
    logic               m_err;
    logic               s_err;
`endif

    // Unmatched select values fall through to zero, which covers the
    // out-of-range codes that exist when NUM_IN is not a power of two.
    always_comb begin
        sel_data = '0;
`ifdef MUXN_PIPE_SEL_ERR_EN
        sel_oor  = 1'b1;
`endif
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = data_in[k*WIDTH +: WIDTH];
`ifdef MUXN_PIPE_SEL_ERR_EN
                sel_oor  = 1'b0;
`endif
            end
        end
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = (state != ST_EMPTY);
    assign out_fire  = out_valid & out_ready;
    assign out_data  = m_data;

    always_comb begin
        state_nxt = state;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_m_in = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && out_fire) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    load_s    = 1'b1;
                    state_nxt = ST_FULL;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so accept cannot be set.
                if (out_fire) begin
                    load_m_s  = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // in_ready is registered from the next state so that out_ready never
    // reaches it combinationally; it stays low for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b0;
            m_data   <= '0;
            s_data   <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_FULL);
            if (load_m_in) begin
                m_data <= sel_data;
            end else if (load_m_s) begin
                m_data <= s_data;
            end
            if (load_s) begin
                s_data <= sel_data;
            end
        end
    end

`ifdef MUXN_PIPE_SEL_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_err <= 1'b0;
            s_err <= 1'b0;
        end else begin
            if (load_m_in) begin
                m_err <= sel_oor;
            end else if (load_m_s) begin
                m_err <= s_err;
            end
            if (load_s) begin
                s_err <= sel_oor;
            end
        end
    end

    assign sel_err = m_err;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// -----------------------------------------------------------------------------
// tb_muxn_pipe
//
// Two instances share clock, reset and handshakes: dut (NUM_IN=4) and dut3
// (NUM_IN=3, exercising out-of-range selects). A reference model treats the
// block as a two-deep FIFO of selected values with a registered ready flag.
// -----------------------------------------------------------------------------
module tb_muxn_pipe;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [1:0]    sel = '0;
    logic [127:0]  data_in = '0;
    logic [1:0]    sel3 = '0;
    logic [95:0]   data3 = '0;

    logic          in_ready, out_valid, in_ready3, out_valid3;
    logic [31:0]   out_data, out_data3;
    logic          err_o, err3_o;

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    muxn_pipe #(.WIDTH(32), .NUM_IN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MUXN_PIPE_SEL_ERR_EN
        , .sel_err(err_o)
`endif
    );

    muxn_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready3),
        .sel(sel3), .data_in(data3),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3)
`ifdef MUXN_PIPE_SEL_ERR_EN
        , .sel_err(err3_o)
`endif
    );

`ifndef MUXN_PIPE_SEL_ERR_EN
    assign err_o  = 1'b0;
    assign err3_o = 1'b0;
`endif

    // ---------------- reference model ----------------
    logic [31:0] qd[$];
    bit          qe[$];
    logic [31:0] q3d[$];
    bit          q3e[$];
    bit          m_rdy = 1'b0;
    bit          m_acc;

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [127:0] d, input int n);
        logic [127:0] dv;
        dv = d;
        if (int'(s) < n) return dv[int'(s)*32 +: 32];
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            qd.delete(); qe.delete(); q3d.delete(); q3e.delete();
            m_rdy = 1'b0;
        end else begin
            m_acc = in_valid && m_rdy;
            if (qd.size() > 0 && out_ready) begin
                void'(qd.pop_front()); void'(qe.pop_front());
                void'(q3d.pop_front()); void'(q3e.pop_front());
            end
            if (m_acc) begin
                qd.push_back(pick(sel, data_in, 4));
                qe.push_back(int'(sel) >= 4);
                q3d.push_back(pick(sel3, {32'd0, data3}, 3));
                q3e.push_back(int'(sel3) >= 3);
            end
            m_rdy = (qd.size() < 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; sel = 2'd1;
        data_in = {32'h4, 32'h3, 32'h2, 32'h1};
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: valid=%b data=%h ready=%b, want 0/0/0",
                         i, out_valid, out_data, in_ready);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic_select();
        data_in = {32'h44, 32'h33, 32'h22, 32'h11};
        out_ready = 1'b1; in_valid = 1'b1; sel = 2'd2;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h33) begin
            failures++;
            $display("FAIL basic_sel2: valid=%b data=%h, want 1/00000033", out_valid, out_data);
        end
        sel = 2'd3;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h44) begin
            failures++;
            $display("FAIL basic_sel3: valid=%b data=%h, want 1/00000044", out_valid, out_data);
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        data_in = {96'd0, 32'hA};
        tick();
        data_in = {96'd0, 32'hB};
        tick();
        tests_run++;
        if (in_ready !== 1'b0 || out_data !== 32'hA || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_full: ready=%b valid=%b data=%h, want 0/1/0000000a",
                     in_ready, out_valid, out_data);
        end
        // Offered while full: must be ignored.
        data_in = {96'd0, 32'hC};
        tick();
        tests_run++;
        if (out_data !== 32'hA || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_stable: data=%h ready=%b, want 0000000a/0", out_data, in_ready);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_second: valid=%b data=%h ready=%b, want 1/0000000b/1",
                     out_valid, out_data, in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp;
        logic [31:0] base;
        base = $urandom;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = {base + 32'(4*i+3), base + 32'(4*i+2), base + 32'(4*i+1), base + 32'(4*i)};
            sel = 2'($urandom_range(0, 3));
            exp = base + 32'(4*i) + 32'(sel);
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d: valid=%b data=%h ready=%b, want 1/%h/1",
                         i, out_valid, out_data, in_ready, exp);
            end
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_out_of_range();
        out_ready = 1'b1; in_valid = 1'b1;
        data3 = {32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1};
        sel3 = 2'd3;
        tick();
        tests_run++;
        if (out_valid3 !== 1'b1 || out_data3 !== 32'd0) begin
            failures++;
            $display("FAIL oor_zero: valid=%b data=%h, want 1/00000000", out_valid3, out_data3);
        end
`ifdef MUXN_PIPE_SEL_ERR_EN
        tests_run++;
        if (err3_o !== 1'b1) begin
            failures++;
            $display("FAIL oor_err_set: sel_err=%b want 1", err3_o);
        end
`endif
        sel3 = 2'd1;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_data3 !== 32'hB2B2B2B2) begin
            failures++;
            $display("FAIL oor_next: data=%h want b2b2b2b2", out_data3);
        end
`ifdef MUXN_PIPE_SEL_ERR_EN
        tests_run++;
        if (err3_o !== 1'b0) begin
            failures++;
            $display("FAIL oor_err_clr: sel_err=%b want 0", err3_o);
        end
`endif
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) >= (i < 200 ? 1 : 3));
            sel       = 2'($urandom_range(0, 3));
            sel3      = 2'($urandom_range(0, 3));
            data_in   = {$urandom, $urandom, $urandom, $urandom};
            data3     = {$urandom, $urandom, $urandom};
            tick();
            tests_run++;
            if (in_ready !== m_rdy || in_ready3 !== m_rdy) begin
                failures++;
                $display("FAIL rnd_ready_%0d: ready=%b ready3=%b want %b", i, in_ready, in_ready3, m_rdy);
            end
            tests_run++;
            if (out_valid !== (qd.size() > 0) || out_valid3 !== (q3d.size() > 0)) begin
                failures++;
                $display("FAIL rnd_valid_%0d: valid=%b valid3=%b want %b", i, out_valid, out_valid3, qd.size() > 0);
            end
            if (qd.size() > 0) begin
                tests_run++;
                if (out_data !== qd[0] || out_data3 !== q3d[0]) begin
                    failures++;
                    $display("FAIL rnd_data_%0d: data=%h data3=%h want %h/%h", i, out_data, out_data3, qd[0], q3d[0]);
                end
`ifdef MUXN_PIPE_SEL_ERR_EN
                tests_run++;
                if (err_o !== qe[0] || err3_o !== q3e[0]) begin
                    failures++;
                    $display("FAIL rnd_err_%0d: err=%b err3=%b want %b/%b", i, err_o, err3_o, qe[0], q3e[0]);
                end
`endif
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset_in_full();
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
        data_in = {32'd0, 32'd0, 32'hDEAD0001, 32'd0};
        tick();
        data_in = {32'd0, 32'd0, 32'hDEAD0002, 32'd0};
        tick();
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rf_fill: ready=%b valid=%b want 0/1", in_ready, out_valid);
        end
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL rf_reset: valid=%b data=%h want 0/00000000", out_valid, out_data);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0 || out_data === 32'hDEAD0001 || out_data === 32'hDEAD0002) begin
                failures++;
                $display("FAIL rf_discard_%0d: valid=%b data=%h want 0 and no stored value",
                         i, out_valid, out_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_select();
        test_backpressure();
        test_streaming();
        test_out_of_range();
        test_random();
        test_reset_in_full();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
